mul_seq_n: RTL
==============

Name: mul_seq_n

Overview:
- Parametrised successor to the lab's 8-bit combinational multiplier datapath: an N-bit iterative shift-add multiplier.
- Two operands are loaded from a shared data bus into holding registers. Multiplication runs on a start/busy/done handshake, in unsigned or two's-complement signed mode.
- The registered 2N-bit product drives N/2 hex display digits through the team's hex_display_decoder (8 segment bits per digit).
- Sits between board switches/buttons and the seven-segment displays.

Parameters:
- N, 8, operand width; must be even and >= 4; product width is 2N; digit count is N/2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high.
- data_in  input  N  operand bus shared by both operand registers.
- load_a  input  1  capture data_in into operand register A.
- load_b  input  1  capture data_in into operand register B.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned. Sampled on the start edge only.
- start  input  1  begin a multiplication.
- busy  output  1  high while computing.
- done  output  1  high from result write until the next accepted start or clr.
- product  output  2N  last completed result, registered.
- segment  output  4N  8 bits per digit; digit i shows product[4i+3:4i] on segment[8i+7:8i].

Behaviour:
- Reset (clr high at an edge): state IDLE; A, B, accumulator, multiplicand, multiplier, count and product all zero; busy=0, done=0. The displays therefore show "0" on every digit. clr overrides every other input and aborts any in-flight operation with no partial product written.
- Operand capture:
  - In IDLE or DONE, load_a/load_b high at an edge writes data_in to A/B.
  - Both high loads the same value into both registers.
  - Loads are ignored while busy.
- States:
  - IDLE: waiting.
  - CALC: iterating, busy=1.
  - DONE: result held, done=1.
- Start acceptance: start is accepted at an edge when the state is IDLE or DONE; the state goes to CALC, done clears, busy sets, and count=0.
  - start while in CALC is ignored; no queuing.
  - If start and a load hit the same edge, the operation uses the pre-edge A/B values, and the load still updates the register for the next operation.
- Operand preparation on the start edge:
  - Unsigned: multiplicand = A, multiplier = B.
  - Signed: multiplicand = |A|, multiplier = |B| as N-bit unsigned; |-2^(N-1)| = 2^(N-1) is representable. Latch neg = A[N-1] XOR B[N-1].
  - Accumulator cleared.
- CALC iteration: each edge adds the multiplicand (zero-extended, shifted by count) to the 2N-bit accumulator if multiplier bit[count] = 1, then count increments.
- Result write: on the N-th CALC edge the final sum is written to product, negated in two's complement if signed and neg=1. The state goes to DONE with busy=0 and done=1 in the same edge.
- Latency: the start edge is edge k; product valid and done=1 after edge k+N. Exactly N cycles of busy=1.
- Product and segment update only on result write or clr. They stay stable during CALC, showing the previous result.
- DONE persists indefinitely. A new start restarts from DONE with no trip through IDLE.
- No overflow is possible: the 2N-bit result is exact for both modes, including signed -2^(N-1) x -2^(N-1) = 2^(2N-2).
- segment is combinational from the product register via the decoders, with no added latency.

Test Plan:
- Reset: clr for 2 cycles mid-CALC (N=8, A=0x0F, B=0x0F, start, clr at cycle 3) -> busy=0, done=0, product=0x0000, all digits decode 0, state IDLE.
- Unsigned max: N=8, load A=0xFF, B=0xFF, signed_mode=0, start -> busy for exactly 8 cycles, done after edge k+8, product=0xFE01, segment digits F,E,0,1.
- Signed mixed and extreme: A=0x80, B=0x7F, signed_mode=1 -> product=0xC080; A=0x80, B=0x80 -> 0x4000; A=0xFF, B=0x01 -> 0xFFFF.
- Handshake: start again at cycle 2 of CALC and toggle load_a with data_in=0x33 -> both ignored, result unchanged, A unchanged. In DONE, start with simultaneous load_a=0x02 (A was 0x03, B=0x05) -> result 0x000F, A reads 0x02 afterwards.
- Back-to-back: start on the first DONE cycle -> done drops next edge, the new result appears N edges later, and product holds the old value throughout CALC.
- Width generalisation: N=16, A=0xFFFF, B=0xFFFF unsigned -> 16 busy cycles, product 0xFFFE0001, 8 digits correct; signed A=0x8000, B=0xFFFF -> 0x00008000.

Source files
------------

// File: rtl/mul_seq_n.sv
// mul_seq_n: N-bit iterative shift-add multiplier with hex display outputs.
//
// Operands are captured from a shared bus into registers A and B. A start
// pulse launches an N-cycle shift-add loop, unsigned or two's-complement
// signed. The registered 2N-bit product is decoded onto N/2 seven-segment
// digits (8 bits per digit, active-high, bit 7 = decimal point, kept off).
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   data_in      operand bus (N bits) shared by A and B
//   load_a       capture data_in into A (IDLE/DONE only)
//   load_b       capture data_in into B (IDLE/DONE only)
//   signed_mode  1 = two's-complement, sampled on the start edge
//   start        begin a multiplication (ignored while busy)
//   busy         high for exactly N cycles while iterating
//   done         high from result write until next start or clr
//   product      last completed 2N-bit result
//   segment      digit i on segment[8i+7:8i] shows product[4i+3:4i]
module mul_seq_n #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   data_in,
  input  logic           load_a,
  input  logic           load_b,
  input  logic           signed_mode,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [4*N-1:0] segment
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]   a_reg, b_reg;
  logic [N-1:0]   mcand, mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;
  logic           neg;
  logic [2*N-1:0] product_reg;

  logic           start_ok;
  logic           last_iter;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] sum;

  // Magnitude of a two's-complement operand as an unsigned N-bit value;
  // the most negative value maps onto 2^(N-1), which still fits.
  function automatic logic [N-1:0] abs_mag(input logic signed [N-1:0] v);
    logic [N-1:0] m;
    m = v[N-1] ? (~v + 1'b1) : v;
    return m;
  endfunction

  function automatic logic [2*N-1:0] negate_2n(input logic [2*N-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [7:0] hex_display_decoder(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  assign start_ok  = start && (state != CALC);
  assign last_iter = (state == CALC) && (count == CW'(N - 1));
  assign addend    = mplier[count] ? ({{N{1'b0}}, mcand} << count) : '0;
  assign sum       = acc + addend;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      neg         <= 1'b0;
      product_reg <= '0;
    end else begin
      // Loads land alongside a start; the operation itself sees the
      // pre-edge A/B because the prep below reads the current registers.
      if (state != CALC) begin
        if (load_a) a_reg <= data_in;
        if (load_b) b_reg <= data_in;
      end
      if (start_ok) begin
        acc   <= '0;
        count <= '0;
        if (signed_mode) begin
          mcand  <= abs_mag($signed(a_reg));
          mplier <= abs_mag($signed(b_reg));
          neg    <= a_reg[N-1] ^ b_reg[N-1];
        end else begin
          mcand  <= a_reg;
          mplier <= b_reg;
          neg    <= 1'b0;
        end
      end else if (state == CALC) begin
        acc   <= sum;
        count <= count + 1'b1;
        if (last_iter) product_reg <= neg ? negate_2n(sum) : sum;
      end
    end
  end

  assign product = product_reg;

  for (genvar i = 0; i < N / 2; i++) begin : g_digit
    assign segment[8*i +: 8] = hex_display_decoder(product_reg[4*i +: 4]);
  end

endmodule
